// File: rtl/dac_c_spi.sv
// Serial write controller for a 16-bit SPI-style DAC: shifts one word MSB-first on cs/sclk/sdi,
// then pulses ldac low. Includes its own async-assert / sync-deassert reset synchronizer.
module dac_c_spi #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 2,
  parameter int unsigned LDAC_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  output logic              rdy,
  output logic              cs,
  output logic              sclk,
  output logic              sdi,
  output logic              ldac
);

  localparam int unsigned CntW = 16;
  localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StGap, StLoad} state_e;

  logic [1:0]        sync_q;
  logic              rst_int_n;
  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              cs_q, cs_d, sclk_q, sclk_d, sdi_q, sdi_d, ldac_q, ldac_d, rdy_q, rdy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end
  assign rst_int_n = sync_q[1];

  // rdy is gated by the first sync stage so it rises on the same edge the FSM leaves reset.
  assign rdy_d = sync_q[0] & (state_d == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= rdy_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    sdi_d   = sdi_q;
    ldac_d  = ldac_q;
    case (state_q)
      StIdle: begin
        if (din_vld && rdy_q) begin
          state_d = StShift;
          sh_d    = din;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          sdi_d   = din[DATA_W-1];
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      StShift: begin
        if (cnt_q == CntW'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BitW'(DATA_W - 1)) begin
              cs_d    = 1'b1;
              sdi_d   = 1'b0;
              state_d = StGap;
            end else begin
              sh_d  = sh_q << 1;
              sdi_d = sh_q[DATA_W-2];
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == CntW'(CS_GAP - 1)) begin
          cnt_d   = '0;
          ldac_d  = 1'b0;
          state_d = StLoad;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLoad: begin
        if (cnt_q == CntW'(LDAC_W - 1)) begin
          cnt_d   = '0;
          ldac_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      sdi_q   <= 1'b0;
      ldac_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      sdi_q   <= sdi_d;
      ldac_q  <= ldac_d;
    end
  end

  assign rdy  = rdy_q;
  assign cs   = cs_q;
  assign sclk = sclk_q;
  assign sdi  = sdi_q;
  assign ldac = ldac_q;

endmodule

// File: tb/tb_dac_c_spi.sv
// Directed bench for dac_c_spi: frame timing, bit order, streaming, mid-frame reset,
// and continuous din_vld with din churn.
module tb_dac_c_spi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = 16'h0000;
  logic        vld_drv = 1'b0;
  logic        stream_en = 1'b0;
  logic        vld_reg = 1'b0;
  logic        din_vld;
  logic        rdy, cs, sclk, sdi, ldac;

  int checks = 0;
  int errors = 0;

  assign din_vld = stream_en ? vld_reg : vld_drv;

  always #5 clk = ~clk;

  dac_c_spi dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (din),
    .din_vld(din_vld),
    .rdy    (rdy),
    .cs     (cs),
    .sclk   (sclk),
    .sdi    (sdi),
    .ldac   (ldac)
  );

  int          cyc = 0;
  int          acc_cnt = 0;
  int          acc_cyc[8];
  int          rise_cnt = 0;
  int          sdi_viol = 0;
  int          ovl_viol = 0;
  int          ldac_low_cnt = 0;
  logic [15:0] bits_cap = 16'h0000;
  logic        sclk_prev = 1'b0;
  logic        sdi_prev = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    vld_reg <= rdy;
    if (din_vld && rdy) begin
      if (acc_cnt < 8) acc_cyc[acc_cnt] <= cyc;
      acc_cnt <= acc_cnt + 1;
    end
  end

  always @(posedge sclk) begin
    if (cs === 1'b0) begin
      bits_cap <= {bits_cap[14:0], sdi};
      rise_cnt <= rise_cnt + 1;
    end
  end

  // sdi may only move while sclk is low, and never on the edge where sclk rises.
  always @(negedge clk) begin
    if (sclk === 1'b1 && sdi !== sdi_prev) sdi_viol <= sdi_viol + 1;
    if (cs === 1'b0 && ldac === 1'b0) ovl_viol <= ovl_viol + 1;
    if (ldac === 1'b0) ldac_low_cnt <= ldac_low_cnt + 1;
    sclk_prev <= sclk;
    sdi_prev  <= sdi;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (rdy !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, rdy}, 32'd1);
  endtask

  // One frame from the accept edge (posedge 0) through rdy returning after posedge 68.
  task automatic run_frame(input string tag, input logic [15:0] w);
    int r0, cs_low, ldac_low;
    logic ldac_bad, rdy_early, cs64;
    wait_rdy({tag, "_rdy_in"});
    din     = w;
    vld_drv = 1'b1;
    r0      = rise_cnt;
    @(posedge clk);
    #1;
    vld_drv = 1'b0;
    din     = ~w;
    chk({tag, "_cs_p0"}, {31'd0, cs}, 32'd0);
    chk({tag, "_rdy_p0"}, {31'd0, rdy}, 32'd0);
    chk({tag, "_sdi_p0"}, {31'd0, sdi}, {31'd0, w[15]});
    cs_low = 0; ldac_low = 0; ldac_bad = 1'b0; rdy_early = 1'b0; cs64 = 1'b0;
    for (int k = 1; k <= 68; k++) begin
      @(posedge clk);
      #1;
      if (cs === 1'b0) cs_low++;
      if (ldac === 1'b0) begin
        ldac_low++;
        if (k != 66 && k != 67) ldac_bad = 1'b1;
      end
      if (k == 64) cs64 = cs;
      if (k < 68 && rdy === 1'b1) rdy_early = 1'b1;
    end
    chk({tag, "_cs_low_cycles"}, cs_low, 32'd63);
    chk({tag, "_cs_high_p64"}, {31'd0, cs64}, 32'd1);
    chk({tag, "_ldac_low_cycles"}, ldac_low, 32'd2);
    chk({tag, "_ldac_window"}, {31'd0, ldac_bad}, 32'd0);
    chk({tag, "_rdy_early"}, {31'd0, rdy_early}, 32'd0);
    chk({tag, "_rdy_p68"}, {31'd0, rdy}, 32'd1);
    chk({tag, "_sclk_rises"}, rise_cnt - r0, 32'd16);
    chk({tag, "_bits"}, {16'd0, bits_cap}, {16'd0, w});
    @(negedge clk);
  endtask

  initial begin
    int a0, r0, l0, n;
    logic [15:0] w;

    // 1. Reset and synchronizer release
    repeat (10) @(negedge clk);
    chk("rst_cs", {31'd0, cs}, 32'd1);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_sdi", {31'd0, sdi}, 32'd0);
    chk("rst_ldac", {31'd0, ldac}, 32'd1);
    chk("rst_rdy", {31'd0, rdy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_rdy_p1", {31'd0, rdy}, 32'd0);
    @(posedge clk);
    #1;
    chk("rel_rdy_p2", {31'd0, rdy}, 32'd1);
    @(negedge clk);

    // 2. Single word
    run_frame("c5f2", 16'hC5F2);

    // 3. Streaming with din_vld = registered rdy
    din       = 16'hC5F2;
    a0        = acc_cnt;
    stream_en = 1'b1;
    n = 0;
    while (acc_cnt < a0 + 4 && n < 400) begin
      @(negedge clk);
      n++;
    end
    stream_en = 1'b0;
    chk("stream_accepts", acc_cnt - a0, 32'd4);
    chk("stream_gap1", acc_cyc[a0+1] - acc_cyc[a0], 32'd70);
    chk("stream_gap2", acc_cyc[a0+2] - acc_cyc[a0+1], 32'd70);
    chk("stream_gap3", acc_cyc[a0+3] - acc_cyc[a0+2], 32'd70);
    wait_rdy("stream_done");
    chk("stream_bits", {16'd0, bits_cap}, 32'h0000C5F2);

    // 4. Bit patterns
    run_frame("p0000", 16'h0000);
    run_frame("pffff", 16'hFFFF);
    run_frame("p8001", 16'h8001);

    // 5. Reset at cycle 30 of a frame
    wait_rdy("mid_rdy_in");
    din     = 16'hA55A;
    vld_drv = 1'b1;
    @(posedge clk);
    #1;
    vld_drv = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    l0    = ldac_low_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_cs", {31'd0, cs}, 32'd1);
    chk("mid_sclk", {31'd0, sclk}, 32'd0);
    chk("mid_sdi", {31'd0, sdi}, 32'd0);
    chk("mid_ldac", {31'd0, ldac}, 32'd1);
    chk("mid_rdy", {31'd0, rdy}, 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    wait_rdy("mid_recover");
    chk("mid_no_ldac", ldac_low_cnt - l0, 32'd0);
    run_frame("mid_clean", 16'h3C96);

    // 6. din_vld held high with din churning mid-frame
    wait_rdy("hold_rdy_in");
    vld_drv = 1'b1;
    for (int f = 0; f < 2; f++) begin
      w  = (f == 0) ? 16'h1234 : 16'hBEEF;
      din = w;
      a0 = acc_cnt;
      r0 = rise_cnt;
      @(posedge clk);
      #1;
      din = 16'($urandom);
      chk("hold_rdy_low", {31'd0, rdy}, 32'd0);
      n = 0;
      while (rdy !== 1'b1 && n < 300) begin
        @(negedge clk);
        n++;
        if (rdy !== 1'b1) din = 16'($urandom);
      end
      chk("hold_rdy_back", {31'd0, rdy}, 32'd1);
      chk("hold_one_accept", acc_cnt - a0, 32'd1);
      chk("hold_rises", rise_cnt - r0, 32'd16);
      chk("hold_bits", {16'd0, bits_cap}, {16'd0, w});
    end
    vld_drv = 1'b0;
    repeat (3) @(negedge clk);

    chk("sdi_stable", sdi_viol, 32'd0);
    chk("cs_ldac_overlap", ovl_viol, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
